scaler_bank_v3: RTL



---
 rtl/scaler_pkg.sv | 27 ++
 rtl/scaler_channel.sv | 84 ++++++++
 rtl/scaler_bank_v3.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/scaler_pkg.sv
`default_nettype none
// ============================================================================
//  scaler_pkg
//  Shared FSM state encodings, readout word layout and address-width helper
//  for the scaler_bank_v3 multi-channel rate scaler.
//  Revision: 3.0
// ============================================================================
package scaler_pkg;

    // Publish FSM states
    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_COPY = 2'd1;
    localparam logic [1:0] c_ST_SWAP = 2'd2;
    localparam logic [1:0] c_ST_PEND = 2'd3;

    // Readout word is {sat, count}: the sat flag sits just above the count
    function automatic int word_sat_bit(input int width);
        return width;
    endfunction

    // Readout address width; a single channel still needs one address bit
    function automatic int calc_aw(input int nch);
        return (nch <= 1) ? 1 : $clog2(nch);
    endfunction

endpackage
`default_nettype wire

// File: rtl/scaler_channel.sv
`default_nettype none
// ============================================================================
//  scaler_channel
//  One scaler lane: rising-edge detect, 2^PRESCALE prescaler, saturating
//  counter with sticky sat flag, and an interval hold register.
//  Revision: 3.0
// ============================================================================
module scaler_channel
    import scaler_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int PRESCALE = 0
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             cnt_i,
    input  logic             tick_i,
    output logic [WIDTH:0]   hold_o
);

    logic             r_cnt_q;
    logic             r_cnt_qq;
    logic             w_edge;
    logic             w_inc;
    logic [WIDTH-1:0] r_count;
    logic             r_sat;
    logic [WIDTH:0]   r_hold;

    // Register the input twice so a rising edge is current-high, previous-low
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_cnt_q  <= 1'b0;
            r_cnt_qq <= 1'b0;
        end else begin
            r_cnt_q  <= cnt_i;
            r_cnt_qq <= r_cnt_q;
        end
    end

    assign w_edge = r_cnt_q & ~r_cnt_qq;

    generate
        if (PRESCALE == 0) begin : g_no_prescale
            assign w_inc = w_edge;
        end else begin : g_prescale
            logic [PRESCALE-1:0] r_pre;

            // Prescaler is free-running across intervals so its residue carries over
            always_ff @(posedge clk_i) begin
                if (!rst_n_i) begin
                    r_pre <= '0;
                end else if (w_edge) begin
                    r_pre <= r_pre + 1'b1;
                end
            end

            assign w_inc = w_edge & (&r_pre);
        end
    endgenerate

    // Saturating count; on tick the interval is latched and a coincident edge opens the new one
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_count <= '0;
            r_sat   <= 1'b0;
            r_hold  <= '0;
        end else if (tick_i) begin
            r_hold[word_sat_bit(WIDTH)] <= r_sat;
            r_hold[WIDTH-1:0]           <= r_count;
            r_count                     <= w_inc ? WIDTH'(1) : '0;
            r_sat                       <= 1'b0;
        end else if (w_inc) begin
            if (&r_count) begin
                r_sat <= 1'b1;
            end else begin
                r_count <= r_count + 1'b1;
            end
        end
    end

    assign hold_o = r_hold;

endmodule
`default_nettype wire

// File: rtl/scaler_bank_v3.sv
`default_nettype none
// ============================================================================
//  scaler_bank_v3
//  Parametrised multi-channel rate scaler. Counts edges per gate interval and
//  publishes all channels into a double-buffered readout RAM, with a read
//  lock that can defer the bank swap, a sequence number and overflow flag.
//  Revision: 3.0
// ============================================================================
module scaler_bank_v3
    import scaler_pkg::*;
#(
    parameter int             NCH           = 32,
    parameter int             WIDTH         = 16,
    parameter int             PRESCALE      = 0,
    parameter logic [NCH-1:0] PRESCALE_MASK = '1,
    parameter int             TICK_DIV      = 33000,
    parameter int             USE_EXT_TICK  = 0,
    parameter int             LOCK_TICKS    = 1,
    parameter int             AW            = calc_aw(NCH)
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic [NCH-1:0]   cnt_i,
    input  logic             ext_tick_i,
    input  logic             rd_i,
    input  logic [AW-1:0]    rd_addr_i,
    output logic [WIDTH-1:0] rd_dat_o,
    output logic             rd_sat_o,
    output logic             rd_valid_o,
    output logic [15:0]      seq_o,
    output logic             tick_o,
    output logic             tick_ovr_o
);

    localparam int            c_DW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [AW-1:0] c_LAST = AW'(NCH - 1);
    localparam logic [AW:0]   c_NCH  = (AW + 1)'(NCH);

    generate
        if (TICK_DIV < NCH + 4) begin : g_bad_tick_div
            $error("scaler_bank_v3: TICK_DIV must be at least NCH+4");
        end
    endgenerate

    logic             w_tick;
    logic [WIDTH:0]   w_hold [NCH];
    logic [WIDTH:0]   r_ram  [2**(AW+1)];
    logic [1:0]       r_state;
    logic [AW-1:0]    r_addr;
    logic             r_bank;
    logic [15:0]      r_seq;
    logic             r_ovr;
    logic             r_published;
    logic             r_lock;
    logic [3:0]       r_lock_ticks;
    logic             r_rd_valid;
    logic [WIDTH:0]   r_rd_word;
    logic             w_rd_set;
    logic             w_rd_clr;

    generate
        if (USE_EXT_TICK != 0) begin : g_ext_tick
            logic r_ext_tick;

            // External strobe is retimed by one cycle
            always_ff @(posedge clk_i) begin
                if (!rst_n_i) begin
                    r_ext_tick <= 1'b0;
                end else begin
                    r_ext_tick <= ext_tick_i;
                end
            end

            assign w_tick = r_ext_tick;
        end else begin : g_int_tick
            logic [c_DW-1:0] r_div;
            logic            w_unused_ext;

            // Free-running gate divider, tick on its terminal count
            always_ff @(posedge clk_i) begin
                if (!rst_n_i) begin
                    r_div <= '0;
                end else if (r_div == c_DW'(TICK_DIV - 1)) begin
                    r_div <= '0;
                end else begin
                    r_div <= r_div + 1'b1;
                end
            end

            assign w_tick       = (r_div == c_DW'(TICK_DIV - 1));
            assign w_unused_ext = ext_tick_i;
        end
    endgenerate

    assign tick_o = w_tick;

    generate
        for (genvar n = 0; n < NCH; n++) begin : g_chan
            scaler_channel #(
                .WIDTH    (WIDTH),
                .PRESCALE (PRESCALE_MASK[n] ? PRESCALE : 0)
            ) u_chan (
                .clk_i   (clk_i),
                .rst_n_i (rst_n_i),
                .cnt_i   (cnt_i[n]),
                .tick_i  (w_tick),
                .hold_o  (w_hold[n])
            );
        end
    endgenerate

    // Publish FSM: copy hold registers into the hidden bank, then swap unless a reader holds the lock
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_state     <= c_ST_IDLE;
            r_addr      <= '0;
            r_bank      <= 1'b0;
            r_seq       <= 16'd0;
            r_ovr       <= 1'b0;
            r_published <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_tick) begin
                        r_state <= c_ST_COPY;
                        r_addr  <= '0;
                    end
                end
                c_ST_COPY: begin
                    if (w_tick) begin
                        r_ovr <= 1'b1;
                    end
                    if (r_addr == c_LAST) begin
                        r_state <= c_ST_SWAP;
                    end else begin
                        r_addr <= r_addr + 1'b1;
                    end
                end
                c_ST_SWAP: begin
                    if (!r_lock) begin
                        r_bank      <= ~r_bank;
                        r_seq       <= r_seq + 16'd1;
                        r_published <= 1'b1;
                        r_state     <= c_ST_IDLE;
                    end else begin
                        r_state <= c_ST_PEND;
                    end
                end
                c_ST_PEND: begin
                    // A new interval supersedes the deferred one
                    if (w_tick) begin
                        r_state <= c_ST_COPY;
                        r_addr  <= '0;
                    end else if (!r_lock) begin
                        r_bank      <= ~r_bank;
                        r_seq       <= r_seq + 16'd1;
                        r_published <= 1'b1;
                        r_state     <= c_ST_IDLE;
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

    // Copy one hold word per cycle into the bank not being presented
    always_ff @(posedge clk_i) begin
        if (rst_n_i && (r_state == c_ST_COPY)) begin
            r_ram[{~r_bank, r_addr}] <= w_hold[r_addr];
        end
    end

    assign w_rd_set = rd_i && (rd_addr_i == '0);
    assign w_rd_clr = rd_i && (rd_addr_i == c_LAST);

    // Read lock: first address takes it, last address drops it, ticks may force it off
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_lock       <= 1'b0;
            r_lock_ticks <= 4'd0;
        end else if (w_rd_clr) begin
            r_lock       <= 1'b0;
            r_lock_ticks <= 4'd0;
        end else if (r_lock && w_tick) begin
            if (r_lock_ticks == 4'(LOCK_TICKS - 1)) begin
                r_lock       <= 1'b0;
                r_lock_ticks <= 4'd0;
            end else begin
                r_lock_ticks <= r_lock_ticks + 4'd1;
            end
        end else if (w_rd_set) begin
            r_lock <= 1'b1;
        end
    end

    // Readout port; nothing is presented until a bank has been published since reset
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_rd_valid <= 1'b0;
            r_rd_word  <= '0;
        end else begin
            r_rd_valid <= rd_i;
            if (rd_i) begin
                if (r_published && ({1'b0, rd_addr_i} < c_NCH)) begin
                    r_rd_word <= r_ram[{r_bank, rd_addr_i}];
                end else begin
                    r_rd_word <= '0;
                end
            end
        end
    end

    assign rd_dat_o   = r_rd_word[WIDTH-1:0];
    assign rd_sat_o   = r_rd_word[word_sat_bit(WIDTH)];
    assign rd_valid_o = r_rd_valid;
    assign seq_o      = r_seq;
    assign tick_ovr_o = r_ovr;

endmodule
`default_nettype wire
